// File: rtl/mm_dbus_ctrl.sv
// mm_dbus_ctrl: runs MM-stage loads/stores as held-request/ack bus transactions and formats load data.
module mm_dbus_ctrl #(
  parameter int ADDR_W = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_address,
  input  logic [31:0]       mem_data_i,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [3:0]        mem_byte_en,
  input  logic              alignment_err,
  input  logic              exception_flush,
  input  logic [2:0]        mem_access_sz,
  input  logic              flag_unsigned,
  input  logic [31:0]       reg_old,
  output logic              stall_o,
  output logic [31:0]       load_data_o,
  output logic              load_valid_o,
  output logic [ADDR_W-1:0] bus_address,
  output logic [31:0]       bus_data_o,
  output logic [3:0]        bus_byte_en,
  output logic              bus_read,
  output logic              bus_write,
  input  logic [31:0]       bus_data_i,
`ifdef MM_DBUS_TIMEOUT_EN
  output logic              bus_err_o,
`endif
  input  logic              bus_ack
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  localparam logic [2:0] ACCESS_SZ_BYTE = 3'd0, ACCESS_SZ_HALF = 3'd1, ACCESS_SZ_LEFT = 3'd3,
                         ACCESS_SZ_RIGHT = 3'd4;
  logic [1:0]  state_q, state_d, a_q;
  logic [31:0] addr_q, wdata_q, reg_old_q, load_q, b_sh, lmask, rmask, fmt;
  logic [15:0] h_sh;
  logic [3:0]  be_q;
  logic [2:0]  sz_q;
  logic        uns_q, kind_rd_q, discard_q, accept, timeout;
`ifdef MM_DBUS_TIMEOUT_EN
  logic [7:0]  cnt_q;
  logic        err_q;
  assign bus_err_o = err_q;
  assign timeout = (cnt_q == 8'(TIMEOUT_CYCLES - 1)) && !bus_ack;
`else
  assign timeout = 1'b0;
`endif
  assign accept = (mem_rd | mem_wr) & ~alignment_err & ~exception_flush;
  assign stall_o = (state_q == IDLE && accept) || state_q == BUSY;
  assign bus_read = state_q == BUSY && kind_rd_q;
  assign bus_write = state_q == BUSY && !kind_rd_q;
  assign load_valid_o = state_q == DONE && kind_rd_q && !discard_q;
  assign load_data_o = load_q;
  assign bus_address = ADDR_W'(addr_q);
  assign bus_data_o = wdata_q;
  assign bus_byte_en = be_q;
  always_comb begin
    state_d = state_q == IDLE ? (accept ? BUSY : IDLE) :
              state_q == BUSY ? ((bus_ack || timeout) ? DONE : BUSY) : IDLE;
    b_sh = bus_data_i >> {a_q, 3'b000};
    h_sh = 16'(bus_data_i >> {a_q[1], 4'b0000});
    lmask = (a_q == 2'd3) ? 32'h0 : (32'hFFFF_FFFF >> {a_q + 2'd1, 3'b000});
    rmask = ~(32'hFFFF_FFFF >> {a_q, 3'b000});
    fmt = sz_q == ACCESS_SZ_BYTE  ? {{24{b_sh[7] & ~uns_q}}, b_sh[7:0]} :
          sz_q == ACCESS_SZ_HALF  ? {{16{h_sh[15] & ~uns_q}}, h_sh} :
          sz_q == ACCESS_SZ_LEFT  ? ((bus_data_i << {~a_q, 3'b000}) | (reg_old_q & lmask)) :
          sz_q == ACCESS_SZ_RIGHT ? (b_sh | (reg_old_q & rmask)) : bus_data_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      a_q       <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      sz_q      <= '0;
      uns_q     <= 1'b0;
      reg_old_q <= '0;
      kind_rd_q <= 1'b0;
      discard_q <= 1'b0;
      load_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && accept) begin
        addr_q    <= {mem_address[31:2], 2'b00};
        a_q       <= mem_address[1:0];
        wdata_q   <= mem_data_i;
        be_q      <= mem_byte_en;
        sz_q      <= mem_access_sz;
        uns_q     <= flag_unsigned;
        reg_old_q <= reg_old;
        kind_rd_q <= mem_rd;
        discard_q <= 1'b0;
      end
      if (state_q == BUSY && (exception_flush || timeout))
        discard_q <= 1'b1;
      if (state_q == BUSY && bus_ack && kind_rd_q && !discard_q && !exception_flush)
        load_q <= fmt;
    end
  end
`ifdef MM_DBUS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == IDLE && accept) ? 8'd0 : (state_q == BUSY && !bus_ack) ? cnt_q + 8'd1 : cnt_q;
      err_q <= state_q == BUSY && timeout;
    end
  end
`endif
endmodule
